load_store_unit: RTL
====================

# load_store_unit

Load/store unit between the execute stage and `datamemory`, which is word-addressed and word-write-only. It converts RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) into word accesses. Loads are aligned and extended into a registered response. Sub-word stores run a two-cycle read-modify-write and stall the pipeline for one cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data word width; the unit is fixed at 32.
- `ADDRESS_WIDTH`, 32, byte address width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  memory request present.
- `req_ready`  out  1  the request completes on this cycle if `req_valid`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word (funct3[1:0]); 11 is treated as word.
- `req_unsigned`  in  1  zero-extend the load (funct3[2]).
- `req_addr`  in  ADDRESS_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, right-justified.
- `resp_valid`  out  1  one-cycle pulse, one cycle after completion.
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores.
- `resp_fault`  out  1  misaligned access; only with the macro, else tied 0.
- `mem_address`  out  ADDRESS_WIDTH  word-aligned address to the memory (bits [1:0] = 00).
- `mem_write_data`  out  DATA_WIDTH  full word to write.
- `mem_write_enable`  out  1  memory write strobe.
- `mem_read_data`  in  DATA_WIDTH  memory read data; combinational, same cycle.

## Operation
- Byte order is little-endian.
  - Byte lane = `req_addr[1:0]`.
  - Half lane = `req_addr[1]`.
- States:
  - IDLE (reset state).
  - MERGE (write phase of a read-modify-write).
- IDLE, load:
  - `mem_address` = aligned `req_addr`; `req_ready` = 1.
  - On the edge, the selected lane is extended and registered into `resp_rdata`; `resp_valid` = 1 in the next cycle.
  - Extension is sign extension unless `req_unsigned` = 1.
- IDLE, word store:
  - `mem_write_enable` = 1 and `mem_write_data` = `req_wdata` in the same cycle; `req_ready` = 1.
- IDLE, byte/half store:
  - `req_ready` = 0; `mem_write_enable` = 0.
  - The merge register captures `mem_read_data` with the target lane replaced by `req_wdata[7:0]` / `[15:0]`.
  - The captured aligned address is held; the state moves to MERGE.
- MERGE:
  - `mem_address` = captured address; `mem_write_data` = merge register; `mem_write_enable` = 1; `req_ready` = 1.
  - The state returns to IDLE.
  - Request inputs are ignored in this cycle; the held request retires here.
- With `req_valid` = 0 in IDLE: `mem_write_enable` = 0, `req_ready` = 1, no response.
- Response after a store: `resp_valid` = 1, `resp_rdata` = 0.
- `mem_write_enable` is never asserted while `rst_n` = 0.

## Timing
- Reset values:
  - State = IDLE.
  - `resp_valid`, `resp_fault` = 0; `resp_rdata` = 0; merge register and captured address = 0.
- Combinational outputs under reset: `req_ready` = 1, `mem_write_enable` = 0.
- Latencies:
  - Load: 1 cycle to response.
  - Word store: write on the acceptance edge; response 1 cycle later.
  - Sub-word store: occupies 2 cycles; write on the 2nd edge; response 1 cycle after that.
- Back-to-back: a new request is accepted in the cycle after MERGE; full throughput otherwise.
- `rst_n` asserted during MERGE: the write is abandoned, memory is unchanged, and the unit returns to IDLE asynchronously.
- Aligned address wrap: `req_addr` = 0xFFFF_FFFF with size byte gives `mem_address` = 0xFFFF_FFFC and lane 3, with no carry.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, is a misaligned access.
  - A misaligned access completes in IDLE with `req_ready` = 1 and no memory write.
  - Its response cycle has `resp_valid` = 1, `resp_fault` = 1, `resp_rdata` = 0.
- Undefined: the low address bits are truncated to the natural alignment; `resp_fault` is tied 0.

## Structure
- Package `lsu_pkg`:
  - Size encoding enum (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`).
  - State enum (`LSU_IDLE`, `LSU_MERGE`).
  - Lane-select helper constants.
- One sub-module, `load_extend`: combinational lane select plus sign/zero extension.
  - Inputs: word, `addr[1:0]`, size, unsigned; output: 32-bit result.
- The store-lane merge stays inline.

## Test plan
- LB from 0x0000_0103, memory word 0x80FF_1234 → `resp_rdata` = 0xFFFF_FF80 one cycle later. LBU at the same address → 0x0000_0080.
- SW 0xDEAD_BEEF to 0x10 → `mem_write_enable` high in the same cycle, `req_ready` = 1. LW 0x10 → 0xDEAD_BEEF.
- SH 0xABCD to 0x12 with word 0x1111_2222:
  - Cycle 1: `req_ready` = 0.
  - Cycle 2: write 0xABCD_2222.
  - Cycle 3: `resp_valid` = 1.
- SB 0x55 to 0x21 followed immediately by LW 0x20 (old word 0xAAAA_AAAA) → the load is accepted the cycle after MERGE and returns 0xAAAA_55AA.
- `rst_n` pulsed low during the MERGE of SB 0x77 to 0x30 → the word at 0x30 is unchanged and the state is IDLE after release.
- With `LSU_MISALIGN_TRAP_EN`: LW from 0x0000_0006 → `resp_fault` = 1, `resp_rdata` = 0, no write. Without the macro: LW from 0x0000_0006 reads word 0x4.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access size encoding,
// FSM states and byte/half lane selectors.
package lsu_pkg;

   localparam int unsigned LSU_XLEN = 32;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned HALF_W   = 16;

   // funct3[1:0] encoding; 2'b11 is handled as a word access
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   typedef enum logic {
      LSU_IDLE  = 1'b0,
      LSU_MERGE = 1'b1
   } state_e;

   localparam logic [1:0] LANE_B0 = 2'd0;
   localparam logic [1:0] LANE_B1 = 2'd1;
   localparam logic [1:0] LANE_B2 = 2'd2;
   localparam logic [1:0] LANE_B3 = 2'd3;
   localparam logic       LANE_H0 = 1'b0;
   localparam logic       LANE_H1 = 1'b1;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a little-endian word and
// sign- or zero-extends it to 32 bits.
module load_extend
   import lsu_pkg::*;
(
   input  logic [LSU_XLEN-1:0] i_word,
   input  logic [1:0]          i_lane,
   input  logic [1:0]          i_size,
   input  logic                i_unsigned,
   output logic [LSU_XLEN-1:0] o_result_c
);

   logic [BYTE_W-1:0] w_byte;
   logic [HALF_W-1:0] w_half;
   logic              w_sign;

   always_comb begin
      w_byte     = i_word[7:0];
      w_half     = i_word[15:0];
      w_sign     = 1'b0;
      o_result_c = i_word;
      case (i_lane)
         LANE_B0: w_byte = i_word[7:0];
         LANE_B1: w_byte = i_word[15:8];
         LANE_B2: w_byte = i_word[23:16];
         LANE_B3: w_byte = i_word[31:24];
         default: w_byte = i_word[7:0];
      endcase
      if (i_lane[1] == LANE_H1) w_half = i_word[31:16];
      case (i_size)
         SIZE_BYTE: begin
            w_sign     = !i_unsigned && w_byte[BYTE_W-1];
            o_result_c = {{(LSU_XLEN-BYTE_W){w_sign}}, w_byte};
         end
         SIZE_HALF: begin
            w_sign     = !i_unsigned && w_half[HALF_W-1];
            o_result_c = {{(LSU_XLEN-HALF_W){w_sign}}, w_half};
         end
         default: o_result_c = i_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only memory: aligned loads with
// extension, sub-word stores via a two-cycle read-modify-write.
// Optional misaligned-access trapping: define LSU_MISALIGN_TRAP_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [1:0]               req_size,
   input  logic                     req_unsigned,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic                     resp_valid,
   output logic [DATA_WIDTH-1:0]    resp_rdata,
   output logic                     resp_fault,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_write_data,
   output logic                     mem_write_enable,
   input  logic [DATA_WIDTH-1:0]    mem_read_data
);

   state_e                   r_state;
   state_e                   w_state_nxt;
   logic                     r_resp_valid;
   logic [DATA_WIDTH-1:0]    r_resp_rdata;
   logic                     r_resp_fault;
   logic [DATA_WIDTH-1:0]    r_merge;
   logic [ADDRESS_WIDTH-1:0] r_addr;

   logic [ADDRESS_WIDTH-1:0] w_aligned;
   logic [DATA_WIDTH-1:0]    w_merge;
   logic [DATA_WIDTH-1:0]    w_load_data;
   logic                     w_is_sub;
   logic                     w_misalign;
   logic                     w_capture;
   logic                     w_done;
   logic                     w_load_done;
   logic                     w_fault;

   assign w_aligned = {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
   assign w_is_sub  = (req_size == SIZE_BYTE) || (req_size == SIZE_HALF);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misalign = ((req_size == SIZE_HALF) && req_addr[0]) ||
                       (req_size[1] && (req_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   load_extend u_load_extend (
      .i_word     (mem_read_data),
      .i_lane     (req_addr[1:0]),
      .i_size     (req_size),
      .i_unsigned (req_unsigned),
      .o_result_c (w_load_data)
   );

   // Store-lane merge: read word with the target byte/half replaced
   always_comb begin
      w_merge = mem_read_data;
      if (req_size == SIZE_BYTE) begin
         case (req_addr[1:0])
            LANE_B0: w_merge[7:0]   = req_wdata[7:0];
            LANE_B1: w_merge[15:8]  = req_wdata[7:0];
            LANE_B2: w_merge[23:16] = req_wdata[7:0];
            LANE_B3: w_merge[31:24] = req_wdata[7:0];
            default: w_merge        = mem_read_data;
         endcase
      end else begin
         case (req_addr[1])
            LANE_H0: w_merge[15:0]  = req_wdata[15:0];
            LANE_H1: w_merge[31:16] = req_wdata[15:0];
            default: w_merge        = mem_read_data;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= LSU_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      req_ready        = 1'b1;
      mem_write_enable = 1'b0;
      mem_address      = w_aligned;
      mem_write_data   = req_wdata;
      w_capture        = 1'b0;
      w_done           = 1'b0;
      w_load_done      = 1'b0;
      w_fault          = 1'b0;
      case (r_state)
         LSU_IDLE: begin
            if (req_valid) begin
               if (w_misalign) begin
                  w_done  = 1'b1;
                  w_fault = 1'b1;
               end else if (req_write && w_is_sub) begin
                  req_ready   = 1'b0;
                  w_capture   = 1'b1;
                  w_state_nxt = LSU_MERGE;
               end else begin
                  w_done           = 1'b1;
                  w_load_done      = !req_write;
                  mem_write_enable = req_write;
               end
            end
         end
         LSU_MERGE: begin
            mem_address      = r_addr;
            mem_write_data   = r_merge;
            mem_write_enable = 1'b1;
            w_done           = 1'b1;
            w_state_nxt      = LSU_IDLE;
         end
         default: w_state_nxt = LSU_IDLE;
      endcase
      // Reset must never let a pending merge reach memory
      if (!rst_n) begin
         req_ready        = 1'b1;
         mem_write_enable = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_fault <= 1'b0;
         r_merge      <= '0;
         r_addr       <= '0;
      end else begin
         r_resp_valid <= w_done;
         r_resp_fault <= w_fault;
         r_resp_rdata <= w_load_done ? w_load_data : '0;
         if (w_capture) begin
            r_merge <= w_merge;
            r_addr  <= w_aligned;
         end
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_fault = r_resp_fault;

endmodule
